uio_bus_arbiter: RTL and testbench

Round-robin arbiter and direction controller for the 8-bit bidirectional `uio` pin bank of the tile top. Up to `NREQ` internal requesters each win the bank for a burst of write beats (drive `uio_out`, `uio_oe`=FF) or read beats (sample `uio_in`). The arbiter alone owns `uio_oe`, and it inserts a turnaround gap after every burst so no two sources drive the pins in the same cycle.

---
 rtl/uio_bus_arbiter.sv | 138 +++++++++++++
 tb/tb_uio_bus_arbiter.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uio_bus_arbiter.sv
// Round-robin arbiter and direction controller for the bidirectional uio pin bank.
// Grants one requester a burst of read or write beats, then forces a turnaround gap.
module uio_bus_arbiter #(
  parameter  int NREQ       = 4,
  parameter  int MAX_BURST  = 8,
  parameter  int TURNAROUND = 1,
  localparam int IW         = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ-1:0]   wr,
  input  logic [8*NREQ-1:0] wdata,
  input  logic [NREQ-1:0]   last,
  output logic [NREQ-1:0]   gnt,
  output logic [7:0]        rdata,
  output logic              rvalid,
  output logic [IW-1:0]     rid,
  output logic              busy,
  input  logic [7:0]        uio_in,
  output logic [7:0]        uio_out,
  output logic [7:0]        uio_oe
);

  typedef enum logic [1:0] {IDLE, ACTIVE, TURN} state_t;

  state_t              state, state_d;
  logic [IW-1:0]       rr_ptr, rr_d, owner, owner_d, pick, rid_d;
  logic [IW:0]         idx_w;
  logic                found, dir, dir_d, rvalid_d, burst_end;
  logic [7:0]          beat_cnt, beat_d, uio_out_d, uio_oe_d, rdata_d;
  logic [3:0]          turn_cnt, turn_d;
  logic [NREQ-1:0]     gnt_d;
  logic [NREQ-1:0][7:0] wlane;

  assign wlane = wdata;

  // First pending requester at or after the rr pointer, wrapping modulo NREQ.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    idx_w = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx_w = {1'b0, rr_ptr} + (IW+1)'(k);
      if (idx_w >= (IW+1)'(NREQ)) idx_w = idx_w - (IW+1)'(NREQ);
      if (!found && req[idx_w[IW-1:0]]) begin
        found = 1'b1;
        pick  = idx_w[IW-1:0];
      end
    end
  end

  always_comb begin
    state_d   = state;
    rr_d      = rr_ptr;
    owner_d   = owner;
    dir_d     = dir;
    beat_d    = beat_cnt;
    turn_d    = turn_cnt;
    gnt_d     = gnt;
    uio_out_d = uio_out;
    uio_oe_d  = uio_oe;
    rdata_d   = rdata;
    rid_d     = rid;
    rvalid_d  = 1'b0;
    burst_end = last[owner] || (({1'b0, beat_cnt} + 9'd1) == 9'(MAX_BURST));
    case (state)
      IDLE: if (found) begin
        gnt_d        = '0;
        gnt_d[pick]  = 1'b1;
        owner_d      = pick;
        dir_d        = wr[pick];
        beat_d       = '0;
        rr_d         = (pick == IW'(NREQ-1)) ? '0 : pick + 1'b1;
        state_d      = ACTIVE;
      end
      ACTIVE: begin
        if (req[owner]) begin
          beat_d = beat_cnt + 8'd1;
          if (dir) begin
            uio_out_d = wlane[owner];
            uio_oe_d  = 8'hFF;
          end else begin
            rdata_d  = uio_in;
            rid_d    = owner;
            rvalid_d = 1'b1;
          end
        end
        // A dropped request abandons the burst but still pays the turnaround.
        if (!req[owner] || burst_end) begin
          gnt_d   = '0;
          state_d = TURN;
          turn_d  = 4'(TURNAROUND);
        end
      end
      TURN: begin
        uio_oe_d  = 8'h00;
        uio_out_d = 8'h00;
        turn_d    = turn_cnt - 4'd1;
        if (turn_cnt == 4'd1) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      rr_ptr   <= '0;
      owner    <= '0;
      dir      <= 1'b0;
      beat_cnt <= '0;
      turn_cnt <= '0;
      gnt      <= '0;
      uio_out  <= '0;
      uio_oe   <= '0;
      rdata    <= '0;
      rvalid   <= 1'b0;
      rid      <= '0;
      busy     <= 1'b0;
    end else begin
      state    <= state_d;
      rr_ptr   <= rr_d;
      owner    <= owner_d;
      dir      <= dir_d;
      beat_cnt <= beat_d;
      turn_cnt <= turn_d;
      gnt      <= gnt_d;
      uio_out  <= uio_out_d;
      uio_oe   <= uio_oe_d;
      rdata    <= rdata_d;
      rvalid   <= rvalid_d;
      rid      <= rid_d;
      busy     <= (state_d != IDLE);
    end
  end

endmodule

// File: tb/tb_uio_bus_arbiter.sv
// Directed bench for uio_bus_arbiter: burst-level reference model checked every
// cycle, plus hand-computed expectations for each scenario.
module tb_uio_bus_arbiter;
  localparam int NREQ = 4;
  localparam int MB   = 3;
  localparam int TA   = 1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [3:0]  req = '0, wr = '0, last = '0;
  logic [31:0] wdata = '0;
  logic [7:0]  uio_in = '0;
  logic [3:0]  gnt;
  logic [7:0]  rdata, uio_out, uio_oe;
  logic        rvalid, busy;
  logic [1:0]  rid;

  int n_tests = 0;
  int n_fail  = 0;

  uio_bus_arbiter #(.NREQ(NREQ), .MAX_BURST(MB), .TURNAROUND(TA)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .wr(wr), .wdata(wdata), .last(last),
    .gnt(gnt), .rdata(rdata), .rvalid(rvalid), .rid(rid), .busy(busy),
    .uio_in(uio_in), .uio_out(uio_out), .uio_oe(uio_oe)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Reference model: phase 0 = waiting, 1 = bursting, 2 = gap after a burst.
  int   m_phase = 0, m_owner = 0, m_beats = 0, m_rr = 0, m_turn = 0;
  bit   m_dir = 0;
  logic [3:0] e_gnt = '0;
  logic [7:0] e_out = '0, e_oe = '0, e_rdata = '0;
  logic       e_rvalid = 0, e_busy = 0;
  logic [1:0] e_rid = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase <= 0; m_rr <= 0; m_beats <= 0; m_turn <= 0;
      e_gnt <= '0; e_out <= '0; e_oe <= '0; e_rdata <= '0;
      e_rvalid <= 0; e_rid <= '0; e_busy <= 0;
    end else begin
      automatic int pick = -1;
      e_rvalid <= 0;
      if (m_phase == 0) begin
        for (int k = 0; k < NREQ; k++)
          if (pick < 0 && req[(m_rr + k) % NREQ]) pick = (m_rr + k) % NREQ;
        if (pick >= 0) begin
          e_gnt   <= 4'b0001 << pick;
          m_owner <= pick;
          m_dir   <= wr[pick];
          m_beats <= 0;
          m_rr    <= (pick + 1) % NREQ;
          m_phase <= 1;
          e_busy  <= 1;
        end
      end else if (m_phase == 1) begin
        if (req[m_owner]) begin
          if (m_dir) begin
            e_out <= wdata[m_owner*8 +: 8];
            e_oe  <= 8'hFF;
          end else begin
            e_rdata  <= uio_in;
            e_rid    <= 2'(m_owner);
            e_rvalid <= 1;
          end
          m_beats <= m_beats + 1;
        end
        if (!req[m_owner] || last[m_owner] || (m_beats + 1 == MB)) begin
          e_gnt   <= '0;
          m_phase <= 2;
          m_turn  <= TA;
        end
      end else begin
        e_oe   <= 8'h00;
        e_out  <= 8'h00;
        m_turn <= m_turn - 1;
        if (m_turn == 1) begin
          m_phase <= 0;
          e_busy  <= 0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("model_gnt",    32'(gnt),     32'(e_gnt));
      chk("model_uio_out", 32'(uio_out), 32'(e_out));
      chk("model_uio_oe", 32'(uio_oe),  32'(e_oe));
      chk("model_rdata",  32'(rdata),   32'(e_rdata));
      chk("model_rvalid", 32'(rvalid),  32'(e_rvalid));
      chk("model_rid",    32'(rid),     32'(e_rid));
      chk("model_busy",   32'(busy),    32'(e_busy));
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    int order[$];
    int gtime[$];
    logic [7:0] got[$];
    int exp_order[5];
    logic [7:0] rv[4];
    int gcnt, ng, cyc, nrv;

    #1 rst_n = 1'b0;
    tick();
    chk("rst_gnt",  32'(gnt), 0);
    chk("rst_oe",   32'(uio_oe), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_rvalid", 32'(rvalid), 0);
    rst_n = 1'b1;
    tick();

    // Round-robin: all four requesting, 2-beat bursts
    req = 4'hF; wr = 4'b0101; wdata = 32'h44332211; uio_in = 8'h3C; last = '0;
    gcnt = 0; ng = 0; cyc = 0;
    for (int c = 0; c < 100; c++) begin
      tick(); cyc++;
      if (gnt != 0) begin
        if (gcnt == 0) begin
          for (int i = 0; i < NREQ; i++) if (gnt[i]) order.push_back(i);
          gtime.push_back(cyc);
          ng++;
        end
        last = (gcnt == 1) ? gnt : 4'b0;
        gcnt++;
      end else begin
        gcnt = 0; last = '0;
        if (ng == 5) break;
      end
    end
    req = '0; last = '0;
    chk("rr_count", 32'(ng), 5);
    exp_order = '{0, 1, 2, 3, 0};
    if (order.size() >= 5)
      for (int k = 0; k < 5; k++) chk($sformatf("rr_order%0d", k), 32'(order[k]), 32'(exp_order[k]));
    if (gtime.size() >= 5)
      for (int k = 0; k < 4; k++) chk($sformatf("rr_gap%0d", k), 32'(gtime[k+1] - gtime[k]), 4);
    tick(); tick();

    // Single write on requester 2
    req = 4'b0100; wr = 4'b0100; wdata = 32'h00A5_0000; last = 4'b0100;
    tick();
    chk("wr_gnt", 32'(gnt), 32'h4);
    chk("wr_busy", 32'(busy), 1);
    chk("wr_oe_pre", 32'(uio_oe), 0);
    tick();
    chk("wr_out", 32'(uio_out), 32'hA5);
    chk("wr_oe", 32'(uio_oe), 32'hFF);
    chk("wr_gnt_off", 32'(gnt), 0);
    req = '0; last = '0;
    tick();
    chk("wr_oe_turn", 32'(uio_oe), 0);
    chk("wr_busy_off", 32'(busy), 0);
    tick(); tick();

    // Read burst on requester 1, closed by MAX_BURST
    rv = '{8'h11, 8'h22, 8'h33, 8'h44};
    req = 4'b0010; wr = 4'b0000; last = '0;
    tick();
    chk("rd_gnt", 32'(gnt), 32'h2);
    uio_in = rv[0];
    for (int k = 0; k < 4; k++) begin
      tick();
      if (rvalid) begin
        got.push_back(rdata);
        chk("rd_rid", 32'(rid), 1);
      end
      if (k < 3) uio_in = rv[k+1];
    end
    req = '0;
    chk("rd_count", 32'(got.size()), 3);
    if (got.size() >= 3) begin
      chk("rd_data0", 32'(got[0]), 32'h11);
      chk("rd_data1", 32'(got[1]), 32'h22);
      chk("rd_data2", 32'(got[2]), 32'h33);
    end
    tick(); tick();

    // Abandon: requester 3 drops after one write beat
    req = 4'b1000; wr = 4'b1000; wdata = 32'h5A00_0000; last = '0;
    tick();
    chk("ab_gnt", 32'(gnt), 32'h8);
    tick();
    chk("ab_beat_out", 32'(uio_out), 32'h5A);
    chk("ab_beat_oe", 32'(uio_oe), 32'hFF);
    req = '0;
    tick();
    chk("ab_gnt_off", 32'(gnt), 0);
    chk("ab_out_hold", 32'(uio_out), 32'h5A);
    tick();
    chk("ab_oe_off", 32'(uio_oe), 0);
    tick(); tick();

    // Direction hold: wr[0] toggles during a read burst
    req = 4'b0001; wr = 4'b0000; last = '0; uio_in = 8'h77;
    tick();
    chk("dh_gnt", 32'(gnt), 32'h1);
    nrv = 0;
    for (int k = 0; k < 3; k++) begin
      wr[0] = ~wr[0];
      tick();
      chk("dh_oe", 32'(uio_oe), 0);
      if (rvalid) nrv++;
    end
    chk("dh_rvalid_count", 32'(nrv), 3);
    req = '0; wr = '0;
    tick(); tick();

    // Asynchronous reset mid-write burst
    req = 4'b0001; wr = 4'b0001; wdata = 32'h0000_00C3; last = '0;
    tick();
    tick();
    chk("rs_oe_before", 32'(uio_oe), 32'hFF);
    #2 rst_n = 1'b0;
    #1;
    chk("rs_oe", 32'(uio_oe), 0);
    chk("rs_gnt", 32'(gnt), 0);
    chk("rs_rvalid", 32'(rvalid), 0);
    chk("rs_out", 32'(uio_out), 0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("rs_regrant", 32'(gnt), 32'h1);
    req = '0;
    tick(); tick(); tick(); tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
